// File: rtl/spi_rev_pkg.sv
// Shared types and helpers for the spi_rev_slave SPI test target.
//   state_t         : FSM states (idle, receiving a word, returning a word)
//   bitrev()        : reverse the low 'width' bits of a word, width <= 32
//   lead_is_rise()  : leading sck edge is the rising edge for this CPOL
//   sample_on_lead(): data is sampled on the leading edge for this CPHA
package spi_rev_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRx   = 2'd1,
        StTx   = 2'd2
    } state_t;

    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] word,
                                                input int unsigned        width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < int'(width)) begin
                r[int'(width) - 1 - i] = word[i];
            end
        end
        return r;
    endfunction

    function automatic logic lead_is_rise(input int unsigned cpol);
        return cpol == 0;
    endfunction

    function automatic logic sample_on_lead(input int unsigned cpha);
        return cpha == 0;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Input conditioning for spi_rev_slave.
// Synchronises sck/ss/mosi into the system clock domain with SYNC_N flops and produces
// registered one-clock sck rise/fall pulses. ss and mosi get one extra flop so they stay
// aligned with the edge pulses (total pin-to-output latency SYNC_N+1 clocks).
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   sck, ss, mosi     : raw SPI pins (asynchronous)
//   ss_s, mosi_s      : synchronised, edge-aligned ss / mosi
//   sck_rise, sck_fall: one-clock pulses for each synchronised sck transition
module spi_sync_edge #(
    parameter int unsigned SYNC_N   = 2,
    parameter logic        SCK_IDLE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic ss_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic [SYNC_N-1:0] sck_sync;
    logic [SYNC_N-1:0] ss_sync;
    logic [SYNC_N-1:0] mosi_sync;
    logic              sck_prev;

    // Chains reset to the bus idle levels so leaving reset never fakes an edge or a select.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= {SYNC_N{SCK_IDLE}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= SCK_IDLE;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            ss_s      <= 1'b1;
            mosi_s    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_N-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_N-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_N-2:0], mosi};
            sck_prev  <= sck_sync[SYNC_N-1];
            sck_rise  <= sck_sync[SYNC_N-1] & ~sck_prev;
            sck_fall  <= ~sck_sync[SYNC_N-1] & sck_prev;
            ss_s      <= ss_sync[SYNC_N-1];
            mosi_s    <= mosi_sync[SYNC_N-1];
        end
    end

endmodule

// File: rtl/spi_rev_slave.sv
// SPI slave test target: receives a DATA_W-bit word (MSB first) and returns it during the
// next DATA_W sck cycles, bit-reversed (REVERSE=1) or echoed (REVERSE=0). Fully synchronous
// to 'clock'; sck/ss/mosi are oversampled, so clock must be at least 4x the sck rate.
// Words alternate receive / reply slots and may run back to back inside one ss frame.
// Optional feature: define SPI_REV_SLAVE_ERR_EN to get the abort pulse and counter;
// otherwise err and err_cnt are tied to zero.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   sck, ss, mosi: SPI inputs (ss active low)
//   miso         : SPI output, idle high
//   rx_data      : last complete received word; rx_valid pulses when it updates
//   busy         : FSM not idle
//   err, err_cnt : abort pulse and saturating abort count
module spi_rev_slave
    import spi_rev_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CPOL    = 0,
    parameter int unsigned CPHA    = 0,
    parameter int unsigned REVERSE = 1,
    parameter int unsigned SYNC_N  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned      CNT_W       = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic             LEAD_RISE   = lead_is_rise(CPOL);
    localparam logic             SAMPLE_LEAD = sample_on_lead(CPHA);
    // Sample on the rising edge when "leading is rise" and "sample on leading" agree.
    localparam logic             SAMPLE_RISE = (LEAD_RISE == SAMPLE_LEAD);

    logic ss_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic sample_edge;
    logic drive_edge;

    spi_sync_edge #(
        .SYNC_N   (SYNC_N),
        .SCK_IDLE (CPOL != 0)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .sck      (sck),
        .ss       (ss),
        .mosi     (mosi),
        .ss_s     (ss_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign drive_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_sh;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] tx_load;

    // Word as it stands once the current sample is shifted in.
    assign rx_word = {rx_sh, mosi_s};
    assign tx_load = (REVERSE != 0) ? DATA_W'(bitrev(32'(rx_word), DATA_W)) : rx_word;
    assign busy    = (state != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StIdle;
            bit_cnt  <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            miso     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            if (ss_s) begin
                // Deselect wins over any coincident sck edge; rx_data is kept.
                state   <= StIdle;
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_sh   <= '0;
                miso    <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        state   <= StRx;
                        bit_cnt <= '0;
                        miso    <= 1'b1;
                    end
                    StRx: begin
                        if (sample_edge) begin
                            rx_sh <= rx_word[DATA_W-2:0];
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= rx_word;
                                rx_valid <= 1'b1;
                                tx_sh    <= tx_load;
                                bit_cnt  <= '0;
                                state    <= StTx;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (drive_edge) begin
                            miso <= 1'b1;
                        end
                    end
                    StTx: begin
                        if (drive_edge) begin
                            miso  <= tx_sh[DATA_W-1];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end else if (sample_edge) begin
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= StRx;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state   <= StIdle;
                        bit_cnt <= '0;
                        miso    <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef SPI_REV_SLAVE_ERR_EN
    logic abort;

    // Deselect seen while a word is partly received or while replying.
    assign abort = ss_s && (((state == StRx) && (bit_cnt != '0)) || (state == StTx));

    always_ff @(posedge clock) begin
        if (reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= abort;
            if (abort && (err_cnt != 8'hff)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule
